// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller for an async FIFO: binary/Gray write pointer, full, almost-full
// and level flags. Define FIFO_WR_OVF_STATUS_EN to add sticky overflow flag and dropped-write count.
module fifo_wr_ptr_ctrl #(
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic              clka,
  input  logic              clka_rst,
  input  logic              winc,
  input  logic [ADDR_W:0]   rq2_rptr_gray,
  input  logic              ovf_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              wovf,
  output logic [7:0]        wovf_cnt
);

  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [PW-1:0] AfThresh = PW'(DEPTH - AF_MARGIN);
  // Full when the write pointer leads the read pointer by exactly DEPTH: top two Gray bits inverted.
  localparam logic [PW-1:0] FullMask = {2'b11, {(PW-2){1'b0}}};

  logic [PW-1:0] wbin_q, wptr_gray_q, wlevel_q;
  logic          wfull_q, walmost_full_q;
  logic [PW-1:0] wbin_next, gray_next, rbin, level_next;
  logic          accept;

  assign accept = winc & ~wfull_q;

  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(rq2_rptr_gray >> i);
    end
  end

  assign wbin_next  = wbin_q + {{(PW-1){1'b0}}, accept};
  assign gray_next  = wbin_next ^ (wbin_next >> 1);
  assign level_next = wbin_next - rbin;

  always_ff @(posedge clka or negedge clka_rst) begin
    if (!clka_rst) begin
      wbin_q         <= '0;
      wptr_gray_q    <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
    end else begin
      wbin_q         <= wbin_next;
      wptr_gray_q    <= gray_next;
      wfull_q        <= (gray_next == (rq2_rptr_gray ^ FullMask));
      walmost_full_q <= (level_next >= AfThresh);
      wlevel_q       <= level_next;
    end
  end

  // Gated by reset so no write leaks to memory while reset is held.
  assign wr_en        = accept & clka_rst;
  assign waddr        = wbin_q[ADDR_W-1:0];
  assign wptr_gray    = wptr_gray_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;

`ifdef FIFO_WR_OVF_STATUS_EN
  logic       wovf_q;
  logic [7:0] wovf_cnt_q;

  always_ff @(posedge clka or negedge clka_rst) begin
    if (!clka_rst) begin
      wovf_q     <= 1'b0;
      wovf_cnt_q <= '0;
    end else if (ovf_clr) begin
      wovf_q     <= 1'b0;
      wovf_cnt_q <= '0;
    end else if (winc && wfull_q) begin
      wovf_q <= 1'b1;
      if (wovf_cnt_q != 8'hFF) begin
        wovf_cnt_q <= wovf_cnt_q + 8'd1;
      end
    end
  end

  assign wovf     = wovf_q;
  assign wovf_cnt = wovf_cnt_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign wovf           = 1'b0;
  assign wovf_cnt       = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Directed bench for fifo_wr_ptr_ctrl: vector table for fill/overflow/drain, plus wrap,
// async-reset and overflow-saturation sequences. Honours FIFO_WR_OVF_STATUS_EN.
module tb_fifo_wr_ptr_ctrl;

`ifdef FIFO_WR_OVF_STATUS_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic       clka = 1'b0;
  logic       clka_rst = 1'b0;
  logic       winc = 1'b0;
  logic [3:0] rq2_rptr_gray = '0;
  logic       ovf_clr = 1'b0;
  logic       wr_en;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       wovf;
  logic [7:0] wovf_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  fifo_wr_ptr_ctrl #(.ADDR_W(3), .AF_MARGIN(2)) dut (
    .clka          (clka),
    .clka_rst      (clka_rst),
    .winc          (winc),
    .rq2_rptr_gray (rq2_rptr_gray),
    .ovf_clr       (ovf_clr),
    .wr_en         (wr_en),
    .waddr         (waddr),
    .wptr_gray     (wptr_gray),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .wlevel        (wlevel),
    .wovf          (wovf),
    .wovf_cnt      (wovf_cnt)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic       winc;
    logic [3:0] rptr;
    logic       clr;
    logic       e_wr_en;
    logic [2:0] e_waddr;
    logic [3:0] e_gray;
    logic       e_full;
    logic       e_af;
    logic [3:0] e_level;
    logic       e_ovf;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic w, logic [3:0] r, logic c, logic we, logic [2:0] wa,
                              logic [3:0] g, logic f, logic af, logic [3:0] lv, logic o,
                              logic [7:0] cnt);
    vec_t v;
    v.winc = w; v.rptr = r; v.clr = c; v.e_wr_en = we; v.e_waddr = wa; v.e_gray = g;
    v.e_full = f; v.e_af = af; v.e_level = lv; v.e_ovf = o; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clka);
    clka_rst = 1'b0;
    winc = 1'b0; ovf_clr = 1'b0; rq2_rptr_gray = '0;
    @(negedge clka);
    clka_rst = 1'b1;
  endtask

  task automatic write_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clka);
      winc = 1'b1;
      @(posedge clka);
    end
    @(negedge clka);
    winc = 1'b0;
  endtask

  function automatic logic [3:0] gray4(logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [3:0] prev_g;
    logic [3:0] wb;
    logic [3:0] diff;

    // Fill 8, drop 3 (overflow), read one with clear, then refill to full.
    vecs[0]  = mk(1, 4'h0, 0, 1, 3'd0, 4'b0001, 0, 0, 4'd1, 0, 8'd0);
    vecs[1]  = mk(1, 4'h0, 0, 1, 3'd1, 4'b0011, 0, 0, 4'd2, 0, 8'd0);
    vecs[2]  = mk(1, 4'h0, 0, 1, 3'd2, 4'b0010, 0, 0, 4'd3, 0, 8'd0);
    vecs[3]  = mk(1, 4'h0, 0, 1, 3'd3, 4'b0110, 0, 0, 4'd4, 0, 8'd0);
    vecs[4]  = mk(1, 4'h0, 0, 1, 3'd4, 4'b0111, 0, 0, 4'd5, 0, 8'd0);
    vecs[5]  = mk(1, 4'h0, 0, 1, 3'd5, 4'b0101, 0, 1, 4'd6, 0, 8'd0);
    vecs[6]  = mk(1, 4'h0, 0, 1, 3'd6, 4'b0100, 0, 1, 4'd7, 0, 8'd0);
    vecs[7]  = mk(1, 4'h0, 0, 1, 3'd7, 4'b1100, 1, 1, 4'd8, 0, 8'd0);
    vecs[8]  = mk(1, 4'h0, 0, 0, 3'd0, 4'b1100, 1, 1, 4'd8, OvfEn, OvfEn ? 8'd1 : 8'd0);
    vecs[9]  = mk(1, 4'h0, 0, 0, 3'd0, 4'b1100, 1, 1, 4'd8, OvfEn, OvfEn ? 8'd2 : 8'd0);
    vecs[10] = mk(1, 4'h0, 0, 0, 3'd0, 4'b1100, 1, 1, 4'd8, OvfEn, OvfEn ? 8'd3 : 8'd0);
    vecs[11] = mk(0, 4'h1, 1, 0, 3'd0, 4'b1100, 0, 1, 4'd7, 0, 8'd0);
    vecs[12] = mk(1, 4'h1, 0, 1, 3'd0, 4'b1101, 1, 1, 4'd8, 0, 8'd0);

    // Reset held with winc high: everything zero, no write enable.
    winc = 1'b1;
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_outs", {waddr, wptr_gray, wfull, walmost_full, wlevel, wovf, wovf_cnt}, 0);
    do_reset();

    foreach (vecs[i]) begin
      @(negedge clka);
      winc = vecs[i].winc; rq2_rptr_gray = vecs[i].rptr; ovf_clr = vecs[i].clr;
      #1;
      chk($sformatf("v%0d wr_en", i), wr_en, vecs[i].e_wr_en);
      chk($sformatf("v%0d waddr", i), waddr, vecs[i].e_waddr);
      @(posedge clka);
      #1;
      chk($sformatf("v%0d wptr_gray", i), wptr_gray, vecs[i].e_gray);
      chk($sformatf("v%0d wfull", i), wfull, vecs[i].e_full);
      chk($sformatf("v%0d walmost_full", i), walmost_full, vecs[i].e_af);
      chk($sformatf("v%0d wlevel", i), wlevel, vecs[i].e_level);
      chk($sformatf("v%0d wovf", i), wovf, vecs[i].e_ovf);
      chk($sformatf("v%0d wovf_cnt", i), wovf_cnt, vecs[i].e_cnt);
    end

    // Wrap: reader keeps pace, so level stays at 1 and the pointer crosses 15 -> 0.
    do_reset();
    wb = '0;
    prev_g = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clka);
      winc = 1'b1; rq2_rptr_gray = gray4(wb);
      @(posedge clka);
      #1;
      wb = wb + 4'd1;
      diff = wptr_gray ^ prev_g;
      chk($sformatf("wrap%0d gray", k), wptr_gray, gray4(wb));
      chk($sformatf("wrap%0d onebit", k), $countones(diff), 1);
      chk($sformatf("wrap%0d wlevel", k), wlevel, 1);
      prev_g = wptr_gray;
    end
    @(negedge clka);
    winc = 1'b0;

    // Async reset mid-burst at level 5, checked between clock edges.
    do_reset();
    write_cycles(5);
    chk("mid_level", wlevel, 5);
    winc = 1'b1;
    @(posedge clka);
    #2;
    clka_rst = 1'b0;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_outs", {waddr, wptr_gray, wfull, walmost_full, wlevel, wovf, wovf_cnt}, 0);
    @(negedge clka);
    winc = 1'b0;
    clka_rst = 1'b1;

    // 300 dropped writes after full.
    do_reset();
    write_cycles(8);
    write_cycles(300);
    #1;
    chk("sat_gray", wptr_gray, 4'b1100);
    chk("sat_wovf", wovf, OvfEn);
    chk("sat_cnt", wovf_cnt, OvfEn ? 8'd255 : 8'd0);
    @(negedge clka);
    ovf_clr = 1'b1; winc = 1'b1;
    @(posedge clka);
    #1;
    chk("clr_wovf", wovf, 0);
    chk("clr_cnt", wovf_cnt, 0);
    @(negedge clka);
    ovf_clr = 1'b0; winc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
